// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: MDU FSM state encoding, MDU counter width and
// the architectural zero-register index.
package pipeline_pkg;

  localparam int unsigned MDU_CNT_W = 6;
  localparam logic [4:0]  REG_ZERO  = 5'd0;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mdu_state_e;

endpackage

// File: rtl/mdu_busy_counter.sv
// Multiply/divide occupancy tracker: a start in IDLE holds o_busy high for
// exactly MDU_LATENCY cycles. Starts arriving while BUSY are ignored.
module mdu_busy_counter
  import pipeline_pkg::*;
#(
  parameter int unsigned MDU_LATENCY = 32
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_start,
  output logic o_busy
);

  localparam logic [MDU_CNT_W-1:0] LAT = MDU_CNT_W'(MDU_LATENCY);

  mdu_state_e           r_state;
  logic [MDU_CNT_W-1:0] r_cnt;
  logic                 r_busy;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_state <= BUSY;
            r_cnt   <= LAT;
            r_busy  <= 1'b1;
          end
        end
        BUSY: begin
          r_cnt <= r_cnt - 1'b1;
          // Leaving on the edge where the count hits zero keeps busy == (cnt != 0).
          if (r_cnt == MDU_CNT_W'(1)) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy = r_busy;

endmodule

// File: rtl/hazard_control.sv
// Pipeline hazard unit: load-use and MDU stalls, taken-branch IF/ID flush.
// Define HAZARD_DELAY_SLOT_EN to honour a branch delay slot (no branch flush).
module hazard_control
  import pipeline_pkg::*;
#(
  parameter int unsigned MDU_LATENCY = 32
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic [4:0] ReadRegA_IN,
  input  logic [4:0] ReadRegB_IN,
  input  logic       UsesA_IN,
  input  logic       UsesB_IN,
  input  logic       UsesHILO_IN,
  input  logic       BranchTaken_IN,
  input  logic       EXMemRead_IN,
  input  logic [4:0] EXWriteRegister_IN,
  input  logic       MDUStart_IN,
  output logic       STALL_PC,
  output logic       STALL_IFID,
  output logic       FLUSH_IFID,
  output logic       STALL_IDEXE,
  output logic       FLUSH_IDEXE,
  output logic       MDUBusy_OUT
);

  logic w_mdu_busy;
  logic w_load_use;
  logic w_mdu_hazard;
  logic w_hazard;
  logic w_branch_flush;

  mdu_busy_counter #(
    .MDU_LATENCY(MDU_LATENCY)
  ) u_mdu_busy_counter (
    .i_clk   (CLOCK),
    .i_rst_n (RESET),
    .i_start (MDUStart_IN),
    .o_busy  (w_mdu_busy)
  );

  always_comb begin
    w_load_use = 1'b0;
    if (EXMemRead_IN && (EXWriteRegister_IN != REG_ZERO)) begin
      w_load_use = (UsesA_IN && (ReadRegA_IN == EXWriteRegister_IN)) ||
                   (UsesB_IN && (ReadRegB_IN == EXWriteRegister_IN));
    end
  end

  assign w_mdu_hazard = w_mdu_busy && UsesHILO_IN;
  assign w_hazard     = w_load_use || w_mdu_hazard;

`ifdef HAZARD_DELAY_SLOT_EN
  // The delay-slot instruction always executes, so a branch never squashes IF/ID.
  assign w_branch_flush = 1'b0 & BranchTaken_IN;
`else
  // Branch operands are not valid while stalled, so a stall masks the flush.
  assign w_branch_flush = BranchTaken_IN && !w_hazard;
`endif

  assign STALL_PC    = w_hazard;
  assign STALL_IFID  = w_hazard;
  assign FLUSH_IDEXE = w_hazard;
  assign STALL_IDEXE = 1'b0;
  assign FLUSH_IFID  = w_branch_flush;
  assign MDUBusy_OUT = w_mdu_busy;

endmodule

// File: tb/tb_hazard_control.sv
// Self-checking bench for hazard_control (MDU_LATENCY=4): directed scenarios
// then random traffic, checked against a rule-level reference model.
module tb_hazard_control;

  localparam int unsigned LAT = 4;

  logic       CLOCK = 1'b0;
  logic       RESET;
  logic [4:0] ReadRegA_IN, ReadRegB_IN, EXWriteRegister_IN;
  logic       UsesA_IN, UsesB_IN, UsesHILO_IN, BranchTaken_IN;
  logic       EXMemRead_IN, MDUStart_IN;
  logic       STALL_PC, STALL_IFID, FLUSH_IFID, STALL_IDEXE, FLUSH_IDEXE, MDUBusy_OUT;

  int tests = 0;
  int fails = 0;
  int busy_left = 0;

  hazard_control #(
    .MDU_LATENCY(LAT)
  ) dut (
    .CLOCK              (CLOCK),
    .RESET              (RESET),
    .ReadRegA_IN        (ReadRegA_IN),
    .ReadRegB_IN        (ReadRegB_IN),
    .UsesA_IN           (UsesA_IN),
    .UsesB_IN           (UsesB_IN),
    .UsesHILO_IN        (UsesHILO_IN),
    .BranchTaken_IN     (BranchTaken_IN),
    .EXMemRead_IN       (EXMemRead_IN),
    .EXWriteRegister_IN (EXWriteRegister_IN),
    .MDUStart_IN        (MDUStart_IN),
    .STALL_PC           (STALL_PC),
    .STALL_IFID         (STALL_IFID),
    .FLUSH_IFID         (FLUSH_IFID),
    .STALL_IDEXE        (STALL_IDEXE),
    .FLUSH_IDEXE        (FLUSH_IDEXE),
    .MDUBusy_OUT        (MDUBusy_OUT)
  );

  always #5 CLOCK = ~CLOCK;

  // Expected {STALL_PC, STALL_IFID, FLUSH_IFID, STALL_IDEXE, FLUSH_IDEXE, MDUBusy_OUT}
  function automatic logic [5:0] expected();
    bit lu, mh, hz, fl, busy;
    busy = (RESET === 1'b1) && (busy_left > 0);
    lu = EXMemRead_IN && (EXWriteRegister_IN != 0) &&
         ((UsesA_IN && ReadRegA_IN == EXWriteRegister_IN) ||
          (UsesB_IN && ReadRegB_IN == EXWriteRegister_IN));
    mh = busy && UsesHILO_IN;
    hz = lu || mh;
`ifdef HAZARD_DELAY_SLOT_EN
    fl = 1'b0;
`else
    fl = BranchTaken_IN && !hz;
`endif
    return {hz, hz, fl, 1'b0, hz, busy};
  endfunction

  task automatic check(input string tag);
    logic [5:0] obs, exp;
    obs = {STALL_PC, STALL_IFID, FLUSH_IFID, STALL_IDEXE, FLUSH_IDEXE, MDUBusy_OUT};
    exp = expected();
    tests++;
    assert (obs === exp)
      else begin
        fails++;
        $error("FAIL %s: observed %b expected %b (busy_left=%0d)", tag, obs, exp, busy_left);
      end
  endtask

  // Check, then advance one clock and update the model from the sampled inputs.
  task automatic step(input string tag);
    #1;
    check(tag);
    @(posedge CLOCK);
    if (busy_left > 0) busy_left--;
    else if (MDUStart_IN) busy_left = LAT;
    #1;
  endtask

  task automatic clear_inputs();
    ReadRegA_IN = '0; ReadRegB_IN = '0; EXWriteRegister_IN = '0;
    UsesA_IN = 1'b0; UsesB_IN = 1'b0; UsesHILO_IN = 1'b0;
    BranchTaken_IN = 1'b0; EXMemRead_IN = 1'b0; MDUStart_IN = 1'b0;
  endtask

  initial begin
    clear_inputs();
    RESET = 1'b0;
    #3;
    check("reset_all_zero");
    #9 RESET = 1'b1;
    @(posedge CLOCK); #1;

    // Load-use on rs: one stall cycle, then clear once the bubble is in EXE.
    EXMemRead_IN = 1'b1; EXWriteRegister_IN = 5'd5; ReadRegA_IN = 5'd5; UsesA_IN = 1'b1;
    step("load_use_rs");
    clear_inputs();
    step("load_use_release");

    // Load into $0 never stalls.
    EXMemRead_IN = 1'b1; EXWriteRegister_IN = 5'd0; ReadRegA_IN = 5'd0; UsesA_IN = 1'b1;
    step("load_r0_no_stall");

    // rt match, and a match on an unused operand.
    clear_inputs();
    EXMemRead_IN = 1'b1; EXWriteRegister_IN = 5'd9; ReadRegB_IN = 5'd9; UsesB_IN = 1'b1;
    step("load_use_rt");
    UsesB_IN = 1'b0; ReadRegA_IN = 5'd9;
    step("load_unused_operand");

    // Taken branch without hazard, then coinciding with load-use.
    clear_inputs();
    BranchTaken_IN = 1'b1;
    step("branch_no_hazard");
    EXMemRead_IN = 1'b1; EXWriteRegister_IN = 5'd7; ReadRegA_IN = 5'd7; UsesA_IN = 1'b1;
    step("branch_with_load_use");
    clear_inputs();
    step("after_branch_idle");

    // MDU: start pulse, then HILO reader stalls exactly LAT cycles.
    MDUStart_IN = 1'b1;
    step("mdu_start_edge");
    MDUStart_IN = 1'b0; UsesHILO_IN = 1'b1;
    step("mdu_busy_1");
    MDUStart_IN = 1'b1;          // ignored while busy
    step("mdu_busy_2_start_ignored");
    MDUStart_IN = 1'b0;
    EXMemRead_IN = 1'b1; EXWriteRegister_IN = 5'd3; ReadRegB_IN = 5'd3; UsesB_IN = 1'b1;
    step("mdu_busy_3_with_load_use");
    clear_inputs(); UsesHILO_IN = 1'b1;
    step("mdu_busy_4");
    MDUStart_IN = 1'b1;          // accepted right after the last busy cycle
    step("mdu_release_restart");
    MDUStart_IN = 1'b0;
    for (int i = 0; i < 5; i++) step("mdu_second_run");

    // Random traffic over a small register set to provoke matches.
    for (int i = 0; i < 300; i++) begin
      ReadRegA_IN        = 5'($urandom_range(0, 3));
      ReadRegB_IN        = 5'($urandom_range(0, 3));
      EXWriteRegister_IN = 5'($urandom_range(0, 3));
      UsesA_IN           = 1'($urandom);
      UsesB_IN           = 1'($urandom);
      UsesHILO_IN        = 1'($urandom);
      BranchTaken_IN     = 1'($urandom);
      EXMemRead_IN       = 1'($urandom);
      MDUStart_IN        = ($urandom_range(0, 7) == 0);
      step("random");
    end

    // Reset asserted during the second busy cycle.
    clear_inputs();
    while (busy_left > 0) step("drain");
    MDUStart_IN = 1'b1;
    step("rst_start");
    MDUStart_IN = 1'b0; UsesHILO_IN = 1'b1;
    step("rst_busy_1");
    #2 RESET = 1'b0; busy_left = 0;
    #1 check("rst_mid_busy_immediate");
    clear_inputs();
    #1 check("rst_inputs_zero");
    @(negedge CLOCK) RESET = 1'b1;
    UsesHILO_IN = 1'b1;
    @(posedge CLOCK); #1;
    step("rst_release_no_stall");
    step("rst_release_no_stall_2");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    fails++;
    $display("FAIL timeout: observed no finish, expected completion before 200000");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "timeout");
  end

endmodule
